// File: rtl/apb_dot_classifier.sv
// APB-attached binary classifier: sign(sum(pixel*weight) + BIAS) over a programmable
// number of packed pixel words held in a local buffer, LANES multiply-accumulates per cycle.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for CTRL.start; APB owns the pixel buffer
// S_PRIME  | accumulator cleared, word 0 address presented to buffer/weights
// S_MAC    | accumulate word n while address n+1 is issued (WORDS cycles)
// S_BIAS   | add sign-extended BIAS
// S_DECIDE | latch cat = ~sign, set done, pulse done_irq
module apb_dot_classifier #(
  parameter int AMBA_WORD  = 24,
  parameter int ADDR_DEPTH = 12,
  parameter int PIXEL_W    = 8,
  parameter int WEIGHT_W   = 5,
  parameter int LANES      = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        PSEL,
  input  logic                        PENABLE,
  input  logic                        PWRITE,
  input  logic [ADDR_DEPTH:0]         PADDR,
  input  logic [AMBA_WORD-1:0]        PWDATA,
  output logic [AMBA_WORD-1:0]        PRDATA,
  output logic                        PREADY,
  output logic                        PSLVERR,
  output logic [ADDR_DEPTH-1:0]       wt_addr,
  input  logic [LANES*WEIGHT_W-1:0]   wt_rdata,
  output logic                        cat_out,
  output logic                        done_irq
);

  localparam int PROD_W = PIXEL_W + WEIGHT_W + 1;
  localparam int ACC_W  = PROD_W + $clog2(LANES) + ADDR_DEPTH + 1;
  localparam int DEPTH  = 2**ADDR_DEPTH;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PRIME  = 3'd1;
  localparam logic [2:0] S_MAC    = 3'd2;
  localparam logic [2:0] S_BIAS   = 3'd3;
  localparam logic [2:0] S_DECIDE = 3'd4;

  localparam logic [ADDR_DEPTH-1:0] REG_CTRL   = ADDR_DEPTH'(0);
  localparam logic [ADDR_DEPTH-1:0] REG_STATUS = ADDR_DEPTH'(1);
  localparam logic [ADDR_DEPTH-1:0] REG_BIAS   = ADDR_DEPTH'(2);
  localparam logic [ADDR_DEPTH-1:0] REG_WORDS  = ADDR_DEPTH'(3);
  localparam logic [ADDR_DEPTH-1:0] REG_ACC    = ADDR_DEPTH'(4);

  localparam logic [ADDR_DEPTH:0] MAX_WORDS = {1'b1, {ADDR_DEPTH{1'b0}}};
  localparam logic [ADDR_DEPTH:0] CNT_ZERO  = '0;
  localparam logic [ADDR_DEPTH:0] CNT_ONE   = (ADDR_DEPTH+1)'(1);
  localparam logic [ADDR_DEPTH:0] CNT_TWO   = (ADDR_DEPTH+1)'(2);

  logic [2:0]                   state_q, state_d;
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic [ADDR_DEPTH-1:0]        addr_q, addr_d;
  logic [ADDR_DEPTH:0]          cnt_q, cnt_d;
  logic signed [AMBA_WORD-1:0]  bias_q, bias_d;
  logic [ADDR_DEPTH:0]          words_q, words_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic                         cat_q, cat_d;
  logic                         irq_q, irq_d;

  logic [AMBA_WORD-1:0]         pix_mem [DEPTH];
  logic [AMBA_WORD-1:0]         buf_rd_q;
  logic                         buf_rd_en;
  logic [ADDR_DEPTH-1:0]        buf_rd_addr;

  logic                         apb_access, buf_sel, reg_mapped, is_busy;
  logic                         start_req, start_ok, buf_we;
  logic [ADDR_DEPTH-1:0]        reg_idx;
  logic [ADDR_DEPTH:0]          words_eff;

  logic signed [PROD_W-1:0]     pix_ext, wt_ext, prod;
  logic signed [ACC_W-1:0]      lane_sum;

  assign apb_access = PSEL & PENABLE;
  assign buf_sel    = PADDR[ADDR_DEPTH];
  assign reg_idx    = PADDR[ADDR_DEPTH-1:0];
  assign reg_mapped = (reg_idx <= REG_ACC);
  assign is_busy    = (state_q != S_IDLE);
  assign start_req  = apb_access & PWRITE & ~buf_sel & (reg_idx == REG_CTRL) & PWDATA[0];
  assign start_ok   = start_req & ~is_busy;
  assign buf_we     = apb_access & PWRITE & buf_sel & ~is_busy;
  assign words_eff  = (words_q > MAX_WORDS) ? MAX_WORDS : words_q;

  // While busy the FSM owns the buffer read port; otherwise APB prefetches in setup phase.
  assign buf_rd_en   = is_busy | (PSEL & ~PENABLE);
  assign buf_rd_addr = is_busy ? addr_q : PADDR[ADDR_DEPTH-1:0];

  always_ff @(posedge clk) begin
    if (buf_we) pix_mem[PADDR[ADDR_DEPTH-1:0]] <= PWDATA;
    if (buf_rd_en) buf_rd_q <= pix_mem[buf_rd_addr];
  end

  always_comb begin
    lane_sum = '0;
    pix_ext  = '0;
    wt_ext   = '0;
    prod     = '0;
    for (int k = 0; k < LANES; k++) begin
      pix_ext  = PROD_W'(buf_rd_q[k*PIXEL_W +: PIXEL_W]);
      wt_ext   = PROD_W'($signed(wt_rdata[k*WEIGHT_W +: WEIGHT_W]));
      prod     = pix_ext * wt_ext;
      lane_sum = lane_sum + ACC_W'(prod);
    end
  end

  always_comb begin
    PSLVERR = 1'b0;
    if (apb_access) begin
      if (buf_sel) PSLVERR = is_busy;
      else         PSLVERR = ~reg_mapped | (start_req & is_busy);
    end
  end

  always_comb begin
    PRDATA = '0;
    if (apb_access && !PWRITE) begin
      if (buf_sel) begin
        if (!is_busy) PRDATA = buf_rd_q;
      end else begin
        case (reg_idx)
          REG_STATUS: PRDATA = AMBA_WORD'({done_q, busy_q, cat_q});
          REG_BIAS:   PRDATA = bias_q;
          REG_WORDS:  PRDATA = AMBA_WORD'(words_q);
          REG_ACC:    PRDATA = AMBA_WORD'(acc_q);
          default:    PRDATA = '0;
        endcase
      end
    end
  end

  always_comb begin
    bias_d  = bias_q;
    words_d = words_q;
    if (apb_access && PWRITE && !buf_sel) begin
      if (reg_idx == REG_BIAS)  bias_d  = PWDATA;
      if (reg_idx == REG_WORDS) words_d = PWDATA[ADDR_DEPTH:0];
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    cat_d   = cat_q;
    irq_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_PRIME;
          acc_d   = '0;
          addr_d  = '0;
          cnt_d   = words_eff;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          cat_d   = 1'b0;
        end
      end
      S_PRIME: begin
        state_d = (cnt_q == CNT_ZERO) ? S_BIAS : S_MAC;
        if (cnt_q > CNT_ONE) addr_d = addr_q + ADDR_DEPTH'(1);
      end
      S_MAC: begin
        acc_d = acc_q + lane_sum;
        cnt_d = cnt_q - CNT_ONE;
        // Stop issuing once the last word's address is out, so the address never wraps.
        if (cnt_q > CNT_TWO) addr_d = addr_q + ADDR_DEPTH'(1);
        if (cnt_q == CNT_ONE) state_d = S_BIAS;
      end
      S_BIAS: begin
        acc_d   = acc_q + ACC_W'(bias_q);
        state_d = S_DECIDE;
      end
      S_DECIDE: begin
        cat_d   = ~acc_q[ACC_W-1];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        irq_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      bias_q  <= '0;
      words_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cat_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      bias_q  <= bias_d;
      words_q <= words_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cat_q   <= cat_d;
      irq_q   <= irq_d;
    end
  end

  assign PREADY   = 1'b1;
  assign wt_addr  = addr_q;
  assign cat_out  = cat_q;
  assign done_irq = irq_q;

endmodule
